// File: rtl/mmio2apb_if.sv
// MMIO request / APB requester bundle for mmio2apb.
// slave is the bridge view; master is the requester+completer view.
interface mmio2apb_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               wr_en_i;
  logic [A_WIDTH-1:0] wr_addr_i;
  logic [D_WIDTH-1:0] wr_data_i;
  logic               rd_en_i;
  logic [A_WIDTH-1:0] rd_addr_i;
  logic               req_ready_o;
  logic [D_WIDTH-1:0] rd_data_o;
  logic               rd_valid_o;
  logic               done_o;
  logic               err_o;
  logic               psel_o;
  logic               penable_o;
  logic               pwrite_o;
  logic [A_WIDTH-1:0] paddr_o;
  logic [D_WIDTH-1:0] pwdata_o;
  logic [D_WIDTH-1:0] prdata_i;
  logic               pready_i;
  logic               pslverr_i;

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i,
    input  rd_en_i, rd_addr_i,
    input  prdata_i, pready_i, pslverr_i,
    output req_ready_o, rd_data_o, rd_valid_o,
    output done_o, err_o,
    output psel_o, penable_o, pwrite_o,
    output paddr_o, pwdata_o
  );

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i,
    output rd_en_i, rd_addr_i,
    output prdata_i, pready_i, pslverr_i,
    input  req_ready_o, rd_data_o, rd_valid_o,
    input  done_o, err_o,
    input  psel_o, penable_o, pwrite_o,
    input  paddr_o, pwdata_o
  );
endinterface

// File: rtl/mmio2apb.sv
// MMIO to APB bridge: one transfer at a time,
// writes win over reads, wait-state timeout.
module mmio2apb #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       pclk_i,
  input  logic       presetn_i,
  mmio2apb_if.slave  bus
);

  localparam int CW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      wcnt;
  logic [A_WIDTH-1:0] paddr_q;
  logic [D_WIDTH-1:0] pwdata_q;
  logic [D_WIDTH-1:0] rd_data_q;
  logic pwrite_q;
  logic done_q, err_q, rd_valid_q;
  logic req_ready, psel, penable;
  logic wr_acc, rd_acc, fin, tmo;

  assign wr_acc = (state == IDLE) && bus.wr_en_i;
  assign rd_acc = (state == IDLE) && !bus.wr_en_i
                  && bus.rd_en_i;
  assign fin = (state == ACCESS) && bus.pready_i;

  // Fires on the wait cycle that brings the count to TIMEOUT.
  assign tmo = (state == ACCESS) && !bus.pready_i
               && (TIMEOUT != 0)
               && (int'(wcnt) + 1 >= TIMEOUT);

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.wr_en_i || bus.rd_en_i)
          state_nx = SETUP;
      end
      SETUP: begin
        psel     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (fin || tmo) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      wcnt       <= '0;
    end else begin
      done_q     <= fin || tmo;
      err_q      <= (fin && bus.pslverr_i) || tmo;
      rd_valid_q <= (fin || tmo) && !pwrite_q;
      if (fin && !pwrite_q)
        rd_data_q <= bus.prdata_i;
      else if (tmo && !pwrite_q)
        rd_data_q <= '0;
      if (wr_acc) begin
        paddr_q  <= bus.wr_addr_i;
        pwdata_q <= bus.wr_data_i;
        pwrite_q <= 1'b1;
      end else if (rd_acc) begin
        paddr_q  <= bus.rd_addr_i;
        pwrite_q <= 1'b0;
      end
      if (wr_acc || rd_acc)
        wcnt <= '0;
      else if (state == ACCESS && !bus.pready_i
               && wcnt != '1)
        wcnt <= wcnt + CW'(1);
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.psel_o      = psel;
  assign bus.penable_o   = penable;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mmio2apb.sv
// Directed bench for mmio2apb: per-cycle expectations
// derived from transaction parameters, checked at negedge.
module tb_mmio2apb;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmio2apb_if #(.A_WIDTH(32), .D_WIDTH(32)) bus ();

  mmio2apb #(
    .A_WIDTH(32),
    .D_WIDTH(32),
    .TIMEOUT(TO)
  ) dut (
    .pclk_i   (clk),
    .presetn_i(rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic        ready, psel, pen, pwr;
    logic        done, err, rvalid;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pen_cnt = 0;
  int rv_cnt = 0;
  int done_cyc = -1;
  int acc_cyc = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input bit ps, input bit pe,
                              input bit pw,
                              input logic [31:0] a,
                              input logic [31:0] d);
    exp_t e;
    e.ready  = !ps;
    e.psel   = ps;
    e.pen    = pe;
    e.pwr    = pw;
    e.done   = 1'b0;
    e.err    = 1'b0;
    e.rvalid = 1'b0;
    e.addr   = a;
    e.wdata  = d;
    e.rdata  = last_rd;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (bus.penable_o === 1'b1) pen_cnt++;
    if (bus.rd_valid_o === 1'b1) rv_cnt++;
    if (bus.done_o === 1'b1) done_cyc = cyc;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("req_ready", 32'(bus.req_ready_o), 32'(e.ready));
      chk("psel", 32'(bus.psel_o), 32'(e.psel));
      chk("penable", 32'(bus.penable_o), 32'(e.pen));
      chk("done", 32'(bus.done_o), 32'(e.done));
      chk("err", 32'(bus.err_o), 32'(e.err));
      chk("rd_valid", 32'(bus.rd_valid_o), 32'(e.rvalid));
      chk("rd_data", bus.rd_data_o, e.rdata);
      if (e.psel) begin
        chk("pwrite", 32'(bus.pwrite_o), 32'(e.pwr));
        chk("paddr", bus.paddr_o, e.addr);
        if (e.pwr) chk("pwdata", bus.pwdata_o, e.wdata);
      end
    end
  end

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.wr_en_i   = 1'b0;
    bus.rd_en_i   = 1'b0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b1;
    bus.prdata_i  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      quiet();
      step(mk(0, 0, 0, '0, '0));
    end
  endtask

  task automatic txn(input bit wr, input bit rd,
                     input logic [31:0] wa,
                     input logic [31:0] wd,
                     input logic [31:0] ra,
                     input int waits, input bit serr,
                     input logic [31:0] prd);
    bit hit;
    int k;
    bit last;
    logic [31:0] a;
    exp_t e;
    hit = (TO != 0) && (waits >= TO);
    k   = hit ? TO : waits + 1;
    a   = wr ? wa : ra;
    pen_cnt = 0;
    rv_cnt  = 0;
    acc_cyc = cyc;
    quiet();
    bus.wr_en_i   = wr;
    bus.rd_en_i   = rd;
    bus.wr_addr_i = wa;
    bus.wr_data_i = wd;
    bus.rd_addr_i = ra;
    step(mk(0, 0, 0, '0, '0));
    // requests while busy must be ignored
    bus.wr_en_i   = 1'b1;
    bus.rd_en_i   = 1'b1;
    bus.wr_addr_i = 32'hDEAD_0000;
    bus.wr_data_i = 32'hFFFF_FFFF;
    bus.rd_addr_i = 32'hBEEF_0000;
    step(mk(1, 0, wr, a, wd));
    for (int i = 0; i < k; i++) begin
      last = (i == k - 1) && !hit;
      bus.pready_i  = last;
      bus.pslverr_i = last ? serr : 1'b1;
      bus.prdata_i  = last ? prd : $urandom;
      step(mk(1, 1, wr, a, wd));
    end
    quiet();
    if (!wr) last_rd = hit ? 32'h0 : prd;
    e = mk(0, 0, 0, '0, '0);
    e.done   = 1'b1;
    e.err    = hit || serr;
    e.rvalid = !wr;
    step(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    bus.rd_addr_i = '0;
    #3;
    chk("rst_ready", 32'(bus.req_ready_o), 1);
    chk("rst_psel", 32'(bus.psel_o), 0);
    chk("rst_pen", 32'(bus.penable_o), 0);
    chk("rst_pwrite", 32'(bus.pwrite_o), 0);
    chk("rst_paddr", bus.paddr_o, 0);
    chk("rst_pwdata", bus.pwdata_o, 0);
    chk("rst_rdata", bus.rd_data_o, 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_rvalid", 32'(bus.rd_valid_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    txn(1, 0, 32'h10, 32'hA5A5_A5A5, '0, 0, 0, '0);
    chk("wr_latency", 32'(done_cyc - acc_cyc), 3);
    chk("wr_pen_cycles", 32'(pen_cnt), 1);

    txn(0, 1, '0, '0, 32'h20, 3, 0, 32'h1234_5678);
    chk("rd3_pen_cycles", 32'(pen_cnt), 4);
    chk("rd3_rvalid_cnt", 32'(rv_cnt), 1);
    chk("rd3_data", bus.rd_data_o, 32'h1234_5678);
    idle(1);

    txn(1, 1, 32'h30, 32'hCAFE_F00D, 32'h34, 1, 0, '0);
    chk("both_rvalid_cnt", 32'(rv_cnt), 0);
    chk("both_pen_cycles", 32'(pen_cnt), 2);

    txn(0, 1, '0, '0, 32'h50, 10, 0, 32'h5555_5555);
    chk("tmo_rd_pen", 32'(pen_cnt), 4);
    chk("tmo_rd_data", bus.rd_data_o, 0);

    txn(1, 0, 32'h54, 32'h0F0F_0F0F, '0, 9, 0, '0);
    chk("tmo_wr_pen", 32'(pen_cnt), 4);

    txn(0, 1, '0, '0, 32'h60, 1, 1, 32'h0BAD_BEEF);
    chk("serr_rd_data", bus.rd_data_o, 32'h0BAD_BEEF);

    txn(1, 0, 32'h64, 32'h1357_9BDF, '0, 2, 1, '0);
    txn(0, 1, '0, '0, 32'h70, 0, 0, 32'h8765_4321);
    idle(1);

    // reset dropped in the second ACCESS cycle
    quiet();
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = 32'h40;
    step(mk(0, 0, 0, '0, '0));
    quiet();
    step(mk(1, 0, 0, 32'h40, '0));
    step(mk(1, 1, 0, 32'h40, '0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(bus.psel_o), 0);
    chk("mid_rst_pen", 32'(bus.penable_o), 0);
    chk("mid_rst_ready", 32'(bus.req_ready_o), 1);
    chk("mid_rst_paddr", bus.paddr_o, 0);
    chk("mid_rst_rdata", bus.rd_data_o, 0);
    @(posedge clk);
    #1;
    bus.pready_i = 1'b1;
    rst_n = 1'b1;
    last_rd = '0;
    done_cyc = -1;
    step(mk(0, 0, 0, '0, '0));
    idle(3);
    chk("rst_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

    txn(0, 1, '0, '0, 32'h80, 0, 0, 32'h2468_ACE0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
